ram_sync_rd_mp: RTL

RAM_SYNC_RD_MP -- requirements
Module: ram_sync_rd_mp

---
 rtl/ram_pkg.sv | 16 +
 rtl/ram_rd_port.sv | 63 ++++++
 rtl/ram_sync_rd_mp.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// ram_pkg
// Shared declarations for the multi-read-port synchronous RAM.
//   state_t  : clear-sweep controller states (ST_CLEAR, ST_RUN)
//   RD_FIRST : collision mode, a same-cycle read sees the old word
//   WR_FIRST : collision mode, a same-cycle read sees the merged new word
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

endpackage

// File: rtl/ram_rd_port.sv
// ram_rd_port
// One read port: captures the word presented on rd_data when rd_req is
// high, then optionally passes it through one extra output stage.
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   rd_req         : accepted read request this cycle
//   rd_data        : word to capture (already collision-resolved by the top)
//   dout           : read data, holds its value between pulses
//   rd_valid       : one-cycle pulse per accepted request
module ram_rd_port #(
    parameter int DWIDTH  = 32,
    parameter int OUT_REG = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rd_req,
    input  logic [DWIDTH-1:0] rd_data,
    output logic [DWIDTH-1:0] dout,
    output logic              rd_valid
);

    logic [DWIDTH-1:0] data_s1;
    logic              valid_s1;

    // Data only moves on a request so dout holds while no pulse is present.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_s1  <= '0;
            valid_s1 <= 1'b0;
        end else begin
            valid_s1 <= rd_req;
            if (rd_req) begin
                data_s1 <= rd_data;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DWIDTH-1:0] data_s2;
            logic              valid_s2;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    data_s2  <= '0;
                    valid_s2 <= 1'b0;
                end else begin
                    valid_s2 <= valid_s1;
                    if (valid_s1) begin
                        data_s2 <= data_s1;
                    end
                end
            end

            assign dout     = data_s2;
            assign rd_valid = valid_s2;
        end else begin : g_no_out_reg
            assign dout     = data_s1;
            assign rd_valid = valid_s1;
        end
    endgenerate

endmodule

// File: rtl/ram_sync_rd_mp.sv
// ram_sync_rd_mp
// DEPTH x DWIDTH RAM with one byte-enabled write port and NRD registered
// read ports. A clear controller sweeps zeros through the whole array after
// reset and on clr_req; the array is usable only while ready is high.
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   clr_req        : start a full zero sweep (ignored while sweeping)
//   ready          : high in RUN, when reads and writes are accepted
//   we, wr_addr,
//   din, be        : write request, byte lane i gated by be[i]
//   rd_en, rd_addr : per-port read request, port k address at [k*AWIDTH +: AWIDTH]
//   dout, rd_valid : per-port read data at [k*DWIDTH +: DWIDTH] and pulse
//
// Handshake: rd_en[k] is accepted only while ready is high; each accepted
// request yields exactly one rd_valid[k] pulse 1 + OUT_REG cycles later with
// dout valid in that same cycle. There is no backpressure; one request per
// port per cycle is sustained.
module ram_sync_rd_mp #(
    parameter int AWIDTH   = 3,
    parameter int DWIDTH   = 32,
    parameter int NRD      = 2,
    parameter int WR_FIRST = 0,
    parameter int OUT_REG  = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clr_req,
    output logic                  ready,
    input  logic                  we,
    input  logic [AWIDTH-1:0]     wr_addr,
    input  logic [DWIDTH-1:0]     din,
    input  logic [DWIDTH/8-1:0]   be,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD*AWIDTH-1:0] rd_addr,
    output logic [NRD*DWIDTH-1:0] dout,
    output logic [NRD-1:0]        rd_valid
);

    import ram_pkg::*;

    localparam int DEPTH  = 2 ** AWIDTH;
    localparam int NBYTES = DWIDTH / 8;

    state_t            state;
    logic [AWIDTH-1:0] clr_cnt;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic              user_wr;
    logic [DWIDTH-1:0] wr_word;

    assign user_wr = (state == ST_RUN) && we;

    // Current word at wr_addr with the enabled bytes replaced by din.
    always_comb begin
        wr_word = mem[wr_addr];
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) begin
                wr_word[8*i +: 8] = din[8*i +: 8];
            end
        end
    end

    // Clear controller. ready is registered alongside state so it changes on
    // the same edges as the state transitions.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (&clr_cnt) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clr_req) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                        ready   <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    clr_cnt <= '0;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; the sweep is what zeroes it.
    always_ff @(posedge clock) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (user_wr) begin
            mem[wr_addr] <= wr_word;
        end
    end

    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd
            logic [AWIDTH-1:0] ra;
            logic [DWIDTH-1:0] rdata;

            assign ra = rd_addr[k*AWIDTH +: AWIDTH];

            // Write-first forwards the merged word; read-first simply sees
            // the array before this edge's write lands.
            if (WR_FIRST == ram_pkg::WR_FIRST) begin : g_wr_first
                assign rdata = (user_wr && (wr_addr == ra)) ? wr_word : mem[ra];
            end else begin : g_rd_first
                assign rdata = mem[ra];
            end

            ram_rd_port #(
                .DWIDTH  (DWIDTH),
                .OUT_REG (OUT_REG)
            ) u_rd_port (
                .clock    (clock),
                .reset_n  (reset_n),
                .rd_req   (ready && rd_en[k]),
                .rd_data  (rdata),
                .dout     (dout[k*DWIDTH +: DWIDTH]),
                .rd_valid (rd_valid[k])
            );
        end
    endgenerate

endmodule
